rram_ofifo_arbiter: RTL and testbench

- Shares the single output data FIFO among `NUM_CORE` RRAM core controllers, which produce read, Hamming-weight and segment results.
- Each core pushes result beats into a one-entry holding slot using the active-low push/full convention of the instruction and data FIFOs.
- A round-robin arbiter with per-burst ownership drains the slots into the shared output FIFO, tagging each beat with its source core.

---
 rtl/rram_ofifo_arbiter_if.sv | 27 ++
 rtl/rram_ofifo_arbiter.sv | 162 ++++++++++++++++
 tb/tb_rram_ofifo_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rram_ofifo_arbiter_if.sv
// Bundle between the RRAM core controllers, the output-FIFO arbiter and the shared output FIFO.
// The slave modport is the arbiter side. The master modport is the core/FIFO side.
interface rram_ofifo_arbiter_if #(
    parameter int NUM_CORE      = 4,
    parameter int DATAOUT_WIDTH = 64
);
    localparam int IW = $clog2(NUM_CORE);

    logic [NUM_CORE-1:0]               push_n_core;
    logic [NUM_CORE-1:0]               last_core;
    logic [NUM_CORE*DATAOUT_WIDTH-1:0] din_core;
    logic [NUM_CORE-1:0]               full_core;
    logic                              push_n_oFIFO;
    logic                              full_oFIFO;
    logic [DATAOUT_WIDTH-1:0]          din_oFIFO;
    logic [IW-1:0]                     CORE_ID_oFIFO;

    modport master (
        output push_n_core, last_core, din_core, full_oFIFO,
        input  full_core, push_n_oFIFO, din_oFIFO, CORE_ID_oFIFO
    );

    modport slave (
        input  push_n_core, last_core, din_core, full_oFIFO,
        output full_core, push_n_oFIFO, din_oFIFO, CORE_ID_oFIFO
    );
endinterface

// File: rtl/rram_ofifo_arbiter.sv
// Round-robin arbiter that drains per-core one-entry result slots into the shared output FIFO.
// Define RRAM_OARB_BURST_LOCK_EN to keep ownership for a whole burst (until last or MAX_BURST).
module rram_ofifo_arbiter #(
    parameter int NUM_CORE      = 4,
    parameter int DATAOUT_WIDTH = 64,
    parameter int MAX_BURST     = 16
) (
    input logic                 CLK,
    input logic                 reset,
    rram_ofifo_arbiter_if.slave io
);
    localparam int          IW = $clog2(NUM_CORE);
    localparam int unsigned NC = NUM_CORE;

    if (NUM_CORE < 2 || MAX_BURST < 1) begin : g_bad_cfg
        $error("rram_ofifo_arbiter: NUM_CORE must be >= 2 and MAX_BURST >= 1");
    end

    typedef enum logic {IDLE, OWN} state_t;

    state_t                   state, state_nxt;
    logic [NUM_CORE-1:0]      slot_valid;
    logic [DATAOUT_WIDTH-1:0] slot_data [NUM_CORE];
    logic [NUM_CORE-1:0]      drain;
    logic [NUM_CORE-1:0]      wr;
    logic [NUM_CORE-1:0]      full_core;
    logic                     owner_drain;
    logic                     release_own;
    logic                     any_valid;
    logic [IW-1:0]            pick;
    logic [IW-1:0]            cand;
    logic [IW-1:0]            owner, owner_nxt;
    logic [IW-1:0]            rr_ptr, rr_ptr_nxt;
    logic                     push_n_q, push_n_nxt;
    logic [DATAOUT_WIDTH-1:0] din_q, din_nxt;
    logic [IW-1:0]            id_q, id_nxt;
`ifdef RRAM_OARB_BURST_LOCK_EN
    localparam int            CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_LIM = CW'(MAX_BURST);
    logic [NUM_CORE-1:0]      slot_last;
    logic [CW-1:0]            beat_cnt, beat_cnt_nxt;
`endif

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (int'(v) == NUM_CORE - 1) ? '0 : v + 1'b1;
    endfunction

    // Only the owner's slot can drain; a draining slot reports not-full so it can refill in the same cycle.
    always_comb begin
        drain       = '0;
        owner_drain = (state == OWN) && slot_valid[owner] && !io.full_oFIFO;
        drain[owner] = owner_drain;
    end

    assign full_core    = slot_valid & ~drain;
    assign wr           = ~io.push_n_core & ~full_core;
    assign io.full_core = full_core;

    // First valid slot at or above rr_ptr, wrapping.
    always_comb begin
        any_valid = 1'b0;
        pick      = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NC; k++) begin
            cand = IW'((32'(rr_ptr) + k) % NC);
            if (!any_valid && slot_valid[cand]) begin
                any_valid = 1'b1;
                pick      = cand;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        rr_ptr_nxt  = rr_ptr;
        push_n_nxt  = 1'b1;
        din_nxt     = din_q;
        id_nxt      = id_q;
        release_own = 1'b0;
`ifdef RRAM_OARB_BURST_LOCK_EN
        beat_cnt_nxt = beat_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (any_valid) begin
                    owner_nxt = pick;
                    state_nxt = OWN;
`ifdef RRAM_OARB_BURST_LOCK_EN
                    beat_cnt_nxt = '0;
`endif
                end
            end
            OWN: begin
                if (owner_drain) begin
                    push_n_nxt = 1'b0;
                    din_nxt    = slot_data[owner];
                    id_nxt     = owner;
`ifdef RRAM_OARB_BURST_LOCK_EN
                    beat_cnt_nxt = beat_cnt + 1'b1;
                    release_own  = slot_last[owner] || (beat_cnt_nxt == BURST_LIM);
`else
                    release_own  = 1'b1;
`endif
                    if (release_own) begin
                        rr_ptr_nxt = wrap_inc(owner);
                        state_nxt  = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            push_n_q <= 1'b1;
            din_q    <= '0;
            id_q     <= '0;
`ifdef RRAM_OARB_BURST_LOCK_EN
            beat_cnt <= '0;
`endif
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            push_n_q <= push_n_nxt;
            din_q    <= din_nxt;
            id_q     <= id_nxt;
`ifdef RRAM_OARB_BURST_LOCK_EN
            beat_cnt <= beat_cnt_nxt;
`endif
        end
    end

    // A write wins over a same-cycle drain, leaving the slot valid with the new beat.
    always_ff @(posedge CLK) begin
        if (reset) begin
            slot_valid <= '0;
        end else begin
            slot_valid <= wr | (slot_valid & ~drain);
        end
    end

    always_ff @(posedge CLK) begin
        for (int unsigned i = 0; i < NC; i++) begin
            if (wr[i]) begin
                slot_data[i] <= io.din_core[i*DATAOUT_WIDTH +: DATAOUT_WIDTH];
`ifdef RRAM_OARB_BURST_LOCK_EN
                slot_last[i] <= io.last_core[i];
`endif
            end
        end
    end

    assign io.push_n_oFIFO  = push_n_q;
    assign io.din_oFIFO     = din_q;
    assign io.CORE_ID_oFIFO = id_q;
endmodule

// File: tb/tb_rram_ofifo_arbiter.sv
// Self-checking bench for rram_ofifo_arbiter: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the slot/ownership rules.
module tb_rram_ofifo_arbiter;
    localparam int N  = 4;
    localparam int W  = 64;
    localparam int MB = 16;
    localparam int IW = 2;
`ifdef RRAM_OARB_BURST_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic CLK = 1'b0;
    logic reset = 1'b1;
    always #5 CLK = ~CLK;

    rram_ofifo_arbiter_if #(.NUM_CORE(N), .DATAOUT_WIDTH(W)) bus ();

    rram_ofifo_arbiter #(.NUM_CORE(N), .DATAOUT_WIDTH(W), .MAX_BURST(MB)) dut (
        .CLK  (CLK),
        .reset(reset),
        .io   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit           m_own;
    int           m_owner, m_ptr, m_cnt;
    bit [N-1:0]   m_sv, m_sl, m_fullc, m_drain;
    logic [W-1:0] m_sd [N];
    bit           m_push_n = 1'b1;
    logic [W-1:0] m_din = '0;
    int           m_id = 0;

    logic [N-1:0]          obs_fullc;
    logic [N+1+IW+W-1:0]   got, want;

    // Per-core pending beats {last, data}, presented only when the core sees room
    logic [W:0] pend [N][64];
    int         ph [N];
    int         pt [N];

    int           out_id [$];
    logic [W-1:0] out_d  [$];
    int           exp_id [$];
    logic [W-1:0] exp_d  [$];

    function automatic bit m_full_now(int i);
        return m_sv[i] && !(m_own && m_owner == i && !bus.full_oFIFO);
    endfunction

    task automatic enq(int core, logic [W-1:0] data, bit last);
        pend[core][pt[core]] = {last, data};
        pt[core]++;
    endtask

    task automatic drive_cores();
        for (int i = 0; i < N; i++) begin
            bus.push_n_core[i] = 1'b1;
            if (ph[i] != pt[i] && !m_full_now(i)) begin
                bus.push_n_core[i]      = 1'b0;
                bus.last_core[i]        = pend[i][ph[i]][W];
                bus.din_core[i*W +: W]  = pend[i][ph[i]][W-1:0];
                ph[i]++;
            end
        end
    endtask

    // One clock: sample inputs mid-cycle, advance the model across the edge, capture DUT vs model.
    task automatic cycle();
        bit           rst, ff;
        bit [N-1:0]   pn, lst;
        logic [N*W-1:0] dn;
        @(negedge CLK);
        rst = reset;
        pn  = bus.push_n_core;
        lst = bus.last_core;
        dn  = bus.din_core;
        ff  = bus.full_oFIFO;
        m_drain = '0;
        if (m_own && m_sv[m_owner] && !ff) m_drain[m_owner] = 1'b1;
        m_fullc   = m_sv & ~m_drain;
        obs_fullc = bus.full_core;
        @(posedge CLK);
        if (rst) begin
            m_own = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_sv = '0;
            m_push_n = 1'b1; m_din = '0; m_id = 0;
        end else begin
            m_push_n = 1'b1;
            if (m_own) begin
                if (m_drain[m_owner]) begin
                    m_push_n = 1'b0;
                    m_din    = m_sd[m_owner];
                    m_id     = m_owner;
                    m_cnt++;
                    if (!LOCK || m_sl[m_owner] || m_cnt == MB) begin
                        m_ptr = (m_owner + 1) % N;
                        m_own = 1'b0;
                    end
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (!m_own && m_sv[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                        m_cnt   = 0;
                        m_own   = 1'b1;
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!pn[i] && !m_fullc[i]) begin
                    m_sv[i] = 1'b1;
                    m_sd[i] = dn[i*W +: W];
                    m_sl[i] = lst[i];
                end else if (m_drain[i]) begin
                    m_sv[i] = 1'b0;
                end
            end
        end
        #1;
        got  = {obs_fullc, bus.push_n_oFIFO, bus.CORE_ID_oFIFO, bus.din_oFIFO};
        want = {m_fullc, m_push_n, IW'(m_id), m_din};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.push_n_core = '1;
        bus.full_oFIFO  = 1'b0;
        for (int i = 0; i < N; i++) begin ph[i] = 0; pt[i] = 0; end
        cycle();
        cycle();
        reset = 1'b0;
        out_id.delete(); out_d.delete(); exp_id.delete(); exp_d.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        for (int c = 0; c < 3; c++) begin
            cycle();
            total++;
            if (got !== want) begin bad++; $display("FAIL reset_model c=%0d got=%h want=%h", c, got, want); end
        end
        total++;
        if ({bus.push_n_oFIFO, bus.CORE_ID_oFIFO, bus.din_oFIFO, bus.full_core} !== {1'b1, 2'd0, 64'd0, 4'd0}) begin
            bad++;
            $display("FAIL reset_values got pn=%b id=%0d d=%h fc=%b want pn=1 id=0 d=0 fc=0",
                     bus.push_n_oFIFO, bus.CORE_ID_oFIFO, bus.din_oFIFO, bus.full_core);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_beat();
        bit exp_pn;
        enq(2, 64'hABCD_ABCD, 1'b1);
        for (int c = 0; c < 14; c++) begin
            bus.full_oFIFO = 1'b0;
            if (c == 5) begin enq(0, 64'hC0, 1'b1); enq(3, 64'hC3, 1'b1); end
            drive_cores();
            cycle();
            total++;
            if (got !== want) begin bad++; $display("FAIL single_model c=%0d got=%h want=%h", c, got, want); end
            if (c <= 2) begin
                exp_pn = (c != 2);
                total++;
                if (bus.push_n_oFIFO !== exp_pn) begin
                    bad++; $display("FAIL single_latency c=%0d got pn=%b want %b", c, bus.push_n_oFIFO, exp_pn);
                end
            end
            if (c == 2) begin
                total++;
                if ({bus.CORE_ID_oFIFO, bus.din_oFIFO} !== {2'd2, 64'hABCD_ABCD}) begin
                    bad++; $display("FAIL single_beat got id=%0d d=%h want id=2 d=abcdabcd", bus.CORE_ID_oFIFO, bus.din_oFIFO);
                end
            end
            if (bus.push_n_oFIFO === 1'b0) begin out_id.push_back(int'(bus.CORE_ID_oFIFO)); out_d.push_back(bus.din_oFIFO); end
        end
        exp_id = '{2, 3, 0};
        exp_d  = '{64'hABCD_ABCD, 64'hC3, 64'hC0};
        total++;
        if (out_id.size() != exp_id.size()) begin bad++; $display("FAIL single_count got=%0d want=%0d", out_id.size(), exp_id.size()); end
        for (int k = 0; k < exp_id.size() && k < out_id.size(); k++) begin
            total++;
            if ({out_id[k], out_d[k]} !== {exp_id[k], exp_d[k]}) begin
                bad++; $display("FAIL single_order k=%0d got id=%0d d=%h want id=%0d d=%h", k, out_id[k], out_d[k], exp_id[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int c = 0; c < 30; c++) begin
            bus.full_oFIFO = 1'b0;
            if (c == 0)  begin enq(0, 64'h10, 1'b1); enq(1, 64'h11, 1'b1); enq(3, 64'h13, 1'b1); end
            if (c == 10) enq(1, 64'h21, 1'b1);
            if (c == 16) begin enq(0, 64'h30, 1'b1); enq(1, 64'h31, 1'b1); enq(3, 64'h33, 1'b1); end
            drive_cores();
            cycle();
            total++;
            if (got !== want) begin bad++; $display("FAIL rr_model c=%0d got=%h want=%h", c, got, want); end
            if (bus.push_n_oFIFO === 1'b0) begin out_id.push_back(int'(bus.CORE_ID_oFIFO)); out_d.push_back(bus.din_oFIFO); end
        end
        exp_id = '{0, 1, 3, 1, 3, 0, 1};
        exp_d  = '{64'h10, 64'h11, 64'h13, 64'h21, 64'h33, 64'h30, 64'h31};
        total++;
        if (out_id.size() != exp_id.size()) begin bad++; $display("FAIL rr_count got=%0d want=%0d", out_id.size(), exp_id.size()); end
        for (int k = 0; k < exp_id.size() && k < out_id.size(); k++) begin
            total++;
            if ({out_id[k], out_d[k]} !== {exp_id[k], exp_d[k]}) begin
                bad++; $display("FAIL rr_order k=%0d got id=%0d d=%h want id=%0d d=%h", k, out_id[k], out_d[k], exp_id[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_burst_lock();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            bus.full_oFIFO = 1'b0;
            if (c == 0) begin enq(1, 64'hEEEE_CCCC, 1'b0); enq(1, 64'hBABA_CABA, 1'b0); enq(1, 64'h1234, 1'b1); end
            if (c == 1) enq(0, 64'h5A5A, 1'b1);
            drive_cores();
            cycle();
            total++;
            if (got !== want) begin bad++; $display("FAIL burst_model c=%0d got=%h want=%h", c, got, want); end
            if (bus.push_n_oFIFO === 1'b0) begin out_id.push_back(int'(bus.CORE_ID_oFIFO)); out_d.push_back(bus.din_oFIFO); end
        end
        if (LOCK) begin
            exp_id = '{1, 1, 1, 0};
            exp_d  = '{64'hEEEE_CCCC, 64'hBABA_CABA, 64'h1234, 64'h5A5A};
        end else begin
            exp_id = '{1, 0, 1, 1};
            exp_d  = '{64'hEEEE_CCCC, 64'h5A5A, 64'hBABA_CABA, 64'h1234};
        end
        total++;
        if (out_id.size() != exp_id.size()) begin bad++; $display("FAIL burst_count got=%0d want=%0d", out_id.size(), exp_id.size()); end
        for (int k = 0; k < exp_id.size() && k < out_id.size(); k++) begin
            total++;
            if ({out_id[k], out_d[k]} !== {exp_id[k], exp_d[k]}) begin
                bad++; $display("FAIL burst_order k=%0d got id=%0d d=%h want id=%0d d=%h", k, out_id[k], out_d[k], exp_id[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        for (int k = 0; k < 6; k++) enq(2, 64'h200 + 64'(k), k == 5);
        for (int c = 0; c < 25; c++) begin
            bus.full_oFIFO = (c >= 4 && c <= 8);
            drive_cores();
            cycle();
            total++;
            if (got !== want) begin bad++; $display("FAIL bp_model c=%0d got=%h want=%h", c, got, want); end
            if (c >= 4 && c <= 8) begin
                total++;
                if ({bus.push_n_oFIFO, obs_fullc[2]} !== 2'b11) begin
                    bad++; $display("FAIL bp_stall c=%0d got pn=%b fc2=%b want pn=1 fc2=1", c, bus.push_n_oFIFO, obs_fullc[2]);
                end
            end
            if (bus.push_n_oFIFO === 1'b0) begin out_id.push_back(int'(bus.CORE_ID_oFIFO)); out_d.push_back(bus.din_oFIFO); end
        end
        bus.full_oFIFO = 1'b0;
        for (int k = 0; k < 6; k++) begin exp_id.push_back(2); exp_d.push_back(64'h200 + 64'(k)); end
        total++;
        if (out_id.size() != exp_id.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", out_id.size(), exp_id.size()); end
        for (int k = 0; k < exp_id.size() && k < out_id.size(); k++) begin
            total++;
            if ({out_id[k], out_d[k]} !== {exp_id[k], exp_d[k]}) begin
                bad++; $display("FAIL bp_order k=%0d got id=%0d d=%h want id=%0d d=%h", k, out_id[k], out_d[k], exp_id[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_forced_release();
        do_reset();
        for (int k = 0; k < 20; k++) enq(0, 64'h3000 + 64'(k), 1'b0);
        for (int c = 0; c < 60; c++) begin
            bus.full_oFIFO = 1'b0;
            if (c == 1) enq(1, 64'h4111, 1'b1);
            drive_cores();
            cycle();
            total++;
            if (got !== want) begin bad++; $display("FAIL forced_model c=%0d got=%h want=%h", c, got, want); end
            if (bus.push_n_oFIFO === 1'b0) begin out_id.push_back(int'(bus.CORE_ID_oFIFO)); out_d.push_back(bus.din_oFIFO); end
        end
        for (int k = 0; k < 20; k++) begin
            if (k == (LOCK ? MB : 1)) begin exp_id.push_back(1); exp_d.push_back(64'h4111); end
            exp_id.push_back(0);
            exp_d.push_back(64'h3000 + 64'(k));
        end
        total++;
        if (out_id.size() != exp_id.size()) begin bad++; $display("FAIL forced_count got=%0d want=%0d", out_id.size(), exp_id.size()); end
        for (int k = 0; k < exp_id.size() && k < out_id.size(); k++) begin
            total++;
            if ({out_id[k], out_d[k]} !== {exp_id[k], exp_d[k]}) begin
                bad++; $display("FAIL forced_order k=%0d got id=%0d d=%h want id=%0d d=%h", k, out_id[k], out_d[k], exp_id[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 4; k++) enq(3, 64'h500 + 64'(k), k == 3);
        for (int c = 0; c < 16; c++) begin
            bus.full_oFIFO = 1'b0;
            reset = (c == 3);
            if (c == 3) for (int i = 0; i < N; i++) ph[i] = pt[i];
            drive_cores();
            cycle();
            total++;
            if (got !== want) begin bad++; $display("FAIL rstmid_model c=%0d got=%h want=%h", c, got, want); end
            if (c == 3) begin
                total++;
                if ({bus.push_n_oFIFO, bus.full_core} !== {1'b1, 4'b0000}) begin
                    bad++; $display("FAIL rstmid_state got pn=%b fc=%b want pn=1 fc=0000", bus.push_n_oFIFO, bus.full_core);
                end
            end
            if (c >= 3 && bus.push_n_oFIFO !== 1'b1) out_id.push_back(int'(bus.CORE_ID_oFIFO));
        end
        reset = 1'b0;
        total++;
        if (out_id.size() != 0) begin bad++; $display("FAIL rstmid_stale got=%0d pushes want=0", out_id.size()); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reset          = ($urandom_range(0, 149) == 0);
            bus.full_oFIFO = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                bus.push_n_core[i]     = ($urandom_range(0, 2) == 0);
                bus.last_core[i]       = ($urandom_range(0, 7) == 0);
                bus.din_core[i*W +: W] = {$urandom, $urandom};
            end
            cycle();
            total++;
            if (got !== want) begin bad++; $display("FAIL random_model c=%0d got=%h want=%h", c, got, want); end
        end
        reset = 1'b0;
        bus.push_n_core = '1;
    endtask

    initial begin
        bus.push_n_core = '1;
        bus.last_core   = '0;
        bus.din_core    = '0;
        bus.full_oFIFO  = 1'b0;
        for (int i = 0; i < N; i++) begin ph[i] = 0; pt[i] = 0; end
        test_reset();
        test_single_beat();
        test_round_robin();
        test_burst_lock();
        test_back_pressure();
        test_forced_release();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
